// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Shared constants for the 15/16 kHz arcade raster generator.
//               Default horizontal/vertical timing, the derived totals and
//               sync windows, bus widths, and a window-compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  // Bus widths
  localparam int C_PX_W  = 9;   // pixel / line counters
  localparam int C_RGB_W = 4;   // RGB444 colour component

  // Default clk_sys cycles per pixel
  localparam int C_CLK_DIV = 4;

  // Default horizontal timing, in pixels
  localparam int C_H_ACTIVE = 288;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 32;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;   // 384

  // Default vertical timing, in lines
  localparam int C_V_ACTIVE = 224;
  localparam int C_V_FP     = 16;
  localparam int C_V_SYNC   = 8;
  localparam int C_V_BP     = 16;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;   // 264

  // Sync windows: [start, end)
  localparam int C_HS_START = C_H_ACTIVE + C_H_FP;                      // 304
  localparam int C_HS_END   = C_HS_START + C_H_SYNC;                    // 336
  localparam int C_VS_START = C_V_ACTIVE + C_V_FP;                      // 240
  localparam int C_VS_END   = C_VS_START + C_V_SYNC;                    // 248

  // Unsigned half-open window test on counter values
  function automatic logic in_window(input logic [C_PX_W-1:0] v,
                                     input logic [C_PX_W-1:0] lo,
                                     input logic [C_PX_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Bus between the raster generator, the game video pipeline
//               (coordinates out, colour back) and the scandoubler (pixel
//               enable, sync, blank, RGB).
//   master : the timing generator
//   slave  : the attached video logic / downstream consumer
//   en_vid            pixel enable pulse
//   px_x, px_y        current pixel coordinates
//   pix_req           coordinates are inside the active area
//   pix_r/g/b         colour returned for the requested pixel
//   video_*_out       registered RGB, aligned with sync/blank
//   hs_out, vs_out    active-low sync
//   blank             high outside the active area
//   frame_start       one-slot pulse at the start of each frame
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic                 en_vid;
  logic [C_PX_W-1:0]    px_x;
  logic [C_PX_W-1:0]    px_y;
  logic                 pix_req;
  logic [C_RGB_W-1:0]   pix_r;
  logic [C_RGB_W-1:0]   pix_g;
  logic [C_RGB_W-1:0]   pix_b;
  logic [C_RGB_W-1:0]   video_r_out;
  logic [C_RGB_W-1:0]   video_g_out;
  logic [C_RGB_W-1:0]   video_b_out;
  logic                 hs_out;
  logic                 vs_out;
  logic                 blank;
  logic                 frame_start;

  modport master (
    output en_vid, px_x, px_y, pix_req,
    input  pix_r, pix_g, pix_b,
    output video_r_out, video_g_out, video_b_out,
    output hs_out, vs_out, blank, frame_start
  );

  modport slave (
    input  en_vid, px_x, px_y, pix_req,
    output pix_r, pix_g, pix_b,
    input  video_r_out, video_g_out, video_b_out,
    input  hs_out, vs_out, blank, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/pixel_ce_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ce_gen
// Description : clk_sys divider producing a one-cycle pixel enable every
//               CLK_DIV cycles. The pulse is registered, so it appears in the
//               cycle after the divider reaches CLK_DIV-1; the first pulse
//               is CLK_DIV cycles after reset release. CLK_DIV must be in
//               2..255 so there is always a low cycle between pulses.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   en_vid  : pixel enable pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_ce_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk_sys,
  input  wire logic reset,
  output logic      en_vid
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_en_vid;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_en_vid <= 1'b0;
    end else begin
      r_en_vid <= (r_div == c_div_last);
      if (r_div == c_div_last) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign en_vid = r_en_vid;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Arcade raster timing generator. Walks (px_x, px_y) across
//               the H_TOTAL x V_TOTAL raster once per pixel slot, requests
//               colour for the active area, and registers RGB, sync, blank
//               and frame_start together one slot after the coordinates.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   vid     : video bus (master side), see video_timing_gen_if
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV  = C_CLK_DIV,
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  wire logic          clk_sys,
  input  wire logic          reset,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [C_PX_W-1:0] c_h_last   = C_PX_W'(H_TOTAL - 1);
  localparam logic [C_PX_W-1:0] c_v_last   = C_PX_W'(V_TOTAL - 1);
  localparam logic [C_PX_W-1:0] c_h_active = C_PX_W'(H_ACTIVE);
  localparam logic [C_PX_W-1:0] c_v_active = C_PX_W'(V_ACTIVE);
  localparam logic [C_PX_W-1:0] c_hs_start = C_PX_W'(H_ACTIVE + H_FP);
  localparam logic [C_PX_W-1:0] c_hs_end   = C_PX_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [C_PX_W-1:0] c_vs_start = C_PX_W'(V_ACTIVE + V_FP);
  localparam logic [C_PX_W-1:0] c_vs_end   = C_PX_W'(V_ACTIVE + V_FP + V_SYNC);

  logic                 w_en_vid;
  logic                 w_pix_req;
  logic [C_PX_W-1:0]    r_px_x;
  logic [C_PX_W-1:0]    r_px_y;
  logic [C_RGB_W-1:0]   r_red;
  logic [C_RGB_W-1:0]   r_green;
  logic [C_RGB_W-1:0]   r_blue;
  logic                 r_hs;
  logic                 r_vs;
  logic                 r_blank;
  logic                 r_frame_start;

  pixel_ce_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_ce_gen (
    .clk_sys (clk_sys),
    .reset   (reset),
    .en_vid  (w_en_vid)
  );

  // Raster counters. The line and frame wrap share one update so px_y
  // never shows V_TOTAL.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_px_x <= '0;
      r_px_y <= '0;
    end else if (w_en_vid) begin
      if (r_px_x == c_h_last) begin
        r_px_x <= '0;
        if (r_px_y == c_v_last) begin
          r_px_y <= '0;
        end else begin
          r_px_y <= r_px_y + 1'b1;
        end
      end else begin
        r_px_x <= r_px_x + 1'b1;
      end
    end
  end

  assign w_pix_req = (r_px_x < c_h_active) && (r_px_y < c_v_active);

  // Output stage: everything here describes the coordinates of the
  // previous slot, which is when the source colour has settled. px_y only
  // moves when px_x wraps, so vsync edges land on line starts.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else if (w_en_vid) begin
      r_red         <= w_pix_req ? vid.pix_r : '0;
      r_green       <= w_pix_req ? vid.pix_g : '0;
      r_blue        <= w_pix_req ? vid.pix_b : '0;
      r_hs          <= ~in_window(r_px_x, c_hs_start, c_hs_end);
      r_vs          <= ~in_window(r_px_y, c_vs_start, c_vs_end);
      r_blank       <= ~w_pix_req;
      r_frame_start <= (r_px_x == '0) && (r_px_y == '0);
    end
  end

  assign vid.en_vid      = w_en_vid;
  assign vid.px_x        = r_px_x;
  assign vid.px_y        = r_px_y;
  assign vid.pix_req     = w_pix_req;
  assign vid.video_r_out = r_red;
  assign vid.video_g_out = r_green;
  assign vid.video_b_out = r_blue;
  assign vid.hs_out      = r_hs;
  assign vid.vs_out      = r_vs;
  assign vid.blank       = r_blank;
  assign vid.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Testbench for video_timing_gen. Three instances share clock
//               and reset: default timing at CLK_DIV=4, default timing at
//               CLK_DIV=2, and a shrunken raster at CLK_DIV=2 so whole
//               frames fit in a short run. A closed-form raster model,
//               indexed by clk_sys edges since reset release, gives every
//               expected output each cycle; literal timings pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] salt = 12'h000;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  video_timing_gen_if vif1 ();
  video_timing_gen_if vif2 ();
  video_timing_gen_if vif3 ();

  video_timing_gen #(.CLK_DIV(4)) u_dut1 (.clk_sys(clk), .reset(reset), .vid(vif1));
  video_timing_gen #(.CLK_DIV(2)) u_dut2 (.clk_sys(clk), .reset(reset), .vid(vif2));
  video_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)
  ) u_dut3 (.clk_sys(clk), .reset(reset), .vid(vif3));

  // Colour source: {x[3:0], y[3:0], A}, optionally scrambled by salt.
  always_comb begin
    vif1.pix_r = vif1.px_x[3:0] ^ salt[11:8];
    vif1.pix_g = vif1.px_y[3:0] ^ salt[7:4];
    vif1.pix_b = 4'hA ^ salt[3:0];
    vif2.pix_r = vif2.px_x[3:0] ^ salt[11:8];
    vif2.pix_g = vif2.px_y[3:0] ^ salt[7:4];
    vif2.pix_b = 4'hA ^ salt[3:0];
    vif3.pix_r = vif3.px_x[3:0] ^ salt[11:8];
    vif3.pix_g = vif3.px_y[3:0] ^ salt[7:4];
    vif3.pix_b = 4'hA ^ salt[3:0];
  end

  typedef struct packed {
    logic       en;
    logic [8:0] x;
    logic [8:0] y;
    logic       req;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
  } obs_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // t = clk_sys edges since reset release. The k-th pixel slot is taken on
  // edge k*d+1; outputs then describe raster position k-1.
  function automatic obs_t model(input int t, input int d,
                                 input int ha, input int hf, input int hsy, input int hb,
                                 input int va, input int vf, input int vsy, input int vb,
                                 input logic [11:0] s);
    obs_t e;
    int ht, vt, n, idx, px, py;
    logic act;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    e = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b1;
    n = (t > 0) ? (t - 1) / d : 0;
    e.en  = (t > 0) && (t % d == 0);
    idx   = n % (ht * vt);
    e.x   = 9'(idx % ht);
    e.y   = 9'(idx / ht);
    e.req = ((idx % ht) < ha) && ((idx / ht) < va);
    if (n > 0) begin
      idx = (n - 1) % (ht * vt);
      px  = idx % ht;
      py  = idx / ht;
      act = (px < ha) && (py < va);
      e.blank = !act;
      e.r  = act ? (4'(px % 16) ^ s[11:8]) : 4'h0;
      e.g  = act ? (4'(py % 16) ^ s[7:4])  : 4'h0;
      e.b  = act ? (4'hA ^ s[3:0])         : 4'h0;
      e.hs = !((px >= ha + hf) && (px < ha + hf + hsy));
      e.vs = !((py >= va + vf) && (py < va + vf + vsy));
      e.fs = (idx == 0);
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input obs_t e, input obs_t a);
    chk({tag, " en_vid"},      int'(a.en),    int'(e.en));
    chk({tag, " px_x"},        int'(a.x),     int'(e.x));
    chk({tag, " px_y"},        int'(a.y),     int'(e.y));
    chk({tag, " pix_req"},     int'(a.req),   int'(e.req));
    chk({tag, " video_r"},     int'(a.r),     int'(e.r));
    chk({tag, " video_g"},     int'(a.g),     int'(e.g));
    chk({tag, " video_b"},     int'(a.b),     int'(e.b));
    chk({tag, " hs_out"},      int'(a.hs),    int'(e.hs));
    chk({tag, " vs_out"},      int'(a.vs),    int'(e.vs));
    chk({tag, " blank"},       int'(a.blank), int'(e.blank));
    chk({tag, " frame_start"}, int'(a.fs),    int'(e.fs));
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Edge-time records and snapshots used by the literal checks
  int t1 = 0, t2 = 0, t3 = 0;
  int en1_rise[$], en2_rise[$], hs1_fall[$], hs1_rise[$], hs2_fall[$];
  int vs3_fall[$], vs3_rise[$], fs3_rise[$];
  logic p_en1, p_en2, p_hs1, p_hs2, p_vs3, p_fs3;
  logic [11:0] snap_rgb_10_5 = 12'h000;
  logic [12:0] snap_287      = 13'h0000;
  logic [12:0] snap_288      = 13'h0000;
  logic [17:0] snap_wrap_pre = 18'h0;
  logic [17:0] snap_wrap_post = 18'h3FFFF;

  obs_t a1, a2, a3;

  always begin
    @(posedge clk);
    if (reset) begin
      t1 = 0; t2 = 0; t3 = 0;
      en1_rise.delete(); en2_rise.delete(); hs1_fall.delete(); hs1_rise.delete();
      hs2_fall.delete(); vs3_fall.delete(); vs3_rise.delete(); fs3_rise.delete();
    end else begin
      t1++; t2++; t3++;
    end
    #1;
    a1 = {vif1.en_vid, vif1.px_x, vif1.px_y, vif1.pix_req, vif1.video_r_out,
          vif1.video_g_out, vif1.video_b_out, vif1.hs_out, vif1.vs_out, vif1.blank,
          vif1.frame_start};
    a2 = {vif2.en_vid, vif2.px_x, vif2.px_y, vif2.pix_req, vif2.video_r_out,
          vif2.video_g_out, vif2.video_b_out, vif2.hs_out, vif2.vs_out, vif2.blank,
          vif2.frame_start};
    a3 = {vif3.en_vid, vif3.px_x, vif3.px_y, vif3.pix_req, vif3.video_r_out,
          vif3.video_g_out, vif3.video_b_out, vif3.hs_out, vif3.vs_out, vif3.blank,
          vif3.frame_start};
    cmp("div4", model(t1, 4, 288, 16, 32, 48, 224, 16, 8, 16, salt), a1);
    cmp("div2", model(t2, 2, 288, 16, 32, 48, 224, 16, 8, 16, salt), a2);
    cmp("small", model(t3, 2, 20, 3, 4, 5, 10, 2, 3, 2, salt), a3);
    if (!reset) begin
      if (!p_en1 && a1.en)  en1_rise.push_back(t1);
      if (!p_en2 && a2.en)  en2_rise.push_back(t2);
      if (p_hs1 && !a1.hs)  hs1_fall.push_back(t1);
      if (!p_hs1 && a1.hs)  hs1_rise.push_back(t1);
      if (p_hs2 && !a2.hs)  hs2_fall.push_back(t2);
      if (p_vs3 && !a3.vs)  vs3_fall.push_back(t3);
      if (!p_vs3 && a3.vs)  vs3_rise.push_back(t3);
      if (!p_fs3 && a3.fs)  fs3_rise.push_back(t3);
      if (t1 == 7725) snap_rgb_10_5 = {a1.r, a1.g, a1.b};
      if (t1 == 1153) snap_287 = {a1.blank, a1.r, a1.g, a1.b};
      if (t1 == 1157) snap_288 = {a1.blank, a1.r, a1.g, a1.b};
      if (t3 == 1087) snap_wrap_pre  = {a3.x, a3.y};
      if (t3 == 1089) snap_wrap_post = {a3.x, a3.y};
    end
    p_en1 = a1.en; p_en2 = a2.en; p_hs1 = a1.hs; p_hs2 = a2.hs;
    p_vs3 = a3.vs; p_fs3 = a3.fs;
  end

  initial begin
    int guard;
    // Reset held 10 cycles, then released away from the clock edge
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (8000) @(posedge clk);
    @(negedge clk);
    chk("en_vid first pulse div4",  qget(en1_rise, 0), 4);
    chk("en_vid second pulse div4", qget(en1_rise, 1), 8);
    chk("en_vid first pulse div2",  qget(en2_rise, 0), 2);
    chk("en_vid second pulse div2", qget(en2_rise, 1), 4);
    chk("hs first fall div4",       qget(hs1_fall, 0), 1221);
    chk("hs low width div4",        qget(hs1_rise, 0) - qget(hs1_fall, 0), 128);
    chk("line period div4",         qget(hs1_fall, 1) - qget(hs1_fall, 0), 1536);
    chk("hs first fall div2",       qget(hs2_fall, 0), 611);
    chk("line period div2",         qget(hs2_fall, 1) - qget(hs2_fall, 0), 768);
    chk("rgb at (10,5)",            int'(snap_rgb_10_5), 'hA5A);
    chk("blank+rgb at x=287",       int'(snap_287), 'h0F0A);
    chk("blank+rgb at x=288",       int'(snap_288), 'h1000);
    chk("small frame_start first",  qget(fs3_rise, 0), 3);
    chk("small frame period",       qget(fs3_rise, 1) - qget(fs3_rise, 0), 1088);
    chk("small vs first fall",      qget(vs3_fall, 0), 771);
    chk("small vs low width",       qget(vs3_rise, 0) - qget(vs3_fall, 0), 192);
    chk("small pos before wrap",    int'(snap_wrap_pre),  int'({9'd31, 9'd16}));
    chk("small pos after wrap",     int'(snap_wrap_post), 0);

    // Reset in the middle of hsync
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (vif1.px_x != 9'd310 && guard < 2000);
    chk("reached px_x 310", int'(vif1.px_x), 310);
    chk("hs low before reset", int'(vif1.hs_out), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset hs_out", int'(vif1.hs_out), 1);
    chk("async reset px_x",   int'(vif1.px_x), 0);
    chk("async reset blank",  int'(vif1.blank), 1);
    chk("async reset en_vid", int'(vif1.en_vid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (1700) @(posedge clk);
    @(negedge clk);
    chk("hs fall after restart", qget(hs1_fall, 0), 1221);

    // Randomised resets, at random points within the cycle, with new colours
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #($urandom_range(2, 4));
      reset = 1'b1;
      #1;
      chk("rand reset hs_out", int'(vif1.hs_out), 1);
      chk("rand reset vs_out", int'(vif3.vs_out), 1);
      salt = 12'($urandom);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(200, 2500)) @(posedge clk);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
